// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: decodes picorv32 native requests onto NUM_SLAVES address regions via a registered valid/ready handshake.
// Define BUS_TIMEOUT_EN to end stalled slave accesses with a bus error after TIMEOUT_CYCLES.
module soc_bus_fabric #(
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     bus_err,
    output logic [31:0]              err_addr
);
    localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam logic [4:0] NS = 5'(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("soc_bus_fabric: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic [SW-1:0] sel;
    logic [SW-1:0] nsel;
    logic mapped;
`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt;
`endif

    assign nsel   = mem_addr[28 +: SW];
    assign mapped = {1'b0, mem_addr[31:28]} < NS;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel       <= '0;
            s_valid   <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (mem_valid) begin
                    s_addr  <= mem_addr;
                    s_wdata <= mem_wdata;
                    s_wstrb <= mem_wstrb;
                    sel     <= nsel;
                    if (mapped) begin
                        s_valid[nsel] <= 1'b1;
                        state         <= ACCESS;
`ifdef BUS_TIMEOUT_EN
                        cnt           <= '0;
`endif
                    end else begin
                        // unmapped: complete with an error, no slave sees the request
                        mem_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        mem_rdata <= ERR_RDATA;
                        err_addr  <= mem_addr;
                        state     <= DONE;
                    end
                end
                ACCESS: if (s_ready[sel]) begin
                    mem_rdata <= s_rdata[{sel, 5'd0} +: 32];
                    s_valid   <= '0;
                    mem_ready <= 1'b1;
                    state     <= DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    s_valid   <= '0;
                    mem_ready <= 1'b1;
                    bus_err   <= 1'b1;
                    mem_rdata <= ERR_RDATA;
                    err_addr  <= s_addr;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 16'd1;
                end
`endif
                DONE: begin
                    mem_ready <= 1'b0;
                    bus_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric: directed checks of decode, wait states, errors, reset and back-to-back accesses.
module tb_soc_bus_fabric;
    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         mem_valid = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_wdata = '0;
    logic [3:0]   mem_wstrb = '0;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready = '0;
    logic [31:0]  slot0 = 32'h1234_5678;
    logic [31:0]  slot1 = 32'h1111_1111;
    logic [31:0]  slot2 = 32'h2222_2222;
    logic [31:0]  slot3 = 32'h3333_3333;
    logic [127:0] s_rdata;
    logic         bus_err;
    logic [31:0]  err_addr;
    int checks = 0;
    int passes = 0;
    int ready_cnt = 0;
    int base;
    int hi;
    logic [3:0] other;

    assign s_rdata = {slot3, slot2, slot1, slot0};

    soc_bus_fabric #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .bus_err(bus_err),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_ready === 1'b1) ready_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        tick;
        tick;
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        reset_n = 1'b1;
        tick;

        // zero-wait read of slave 0
        base = ready_cnt;
        s_ready = 4'b0001;
        mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'b0000;
        tick;
        check("rd0_s_valid", 32'(s_valid), 32'h1);
        check("rd0_s_addr", s_addr, 32'h0000_0010);
        check("rd0_ready_early", 32'(mem_ready), 32'd0);
        tick;
        check("rd0_mem_ready", 32'(mem_ready), 32'd1);
        check("rd0_mem_rdata", mem_rdata, 32'h1234_5678);
        check("rd0_bus_err", 32'(bus_err), 32'd0);
        check("rd0_s_valid_off", 32'(s_valid), 32'd0);
        mem_valid = 1'b0;
        tick;
        check("rd0_ready_pulse", 32'(mem_ready), 32'd0);
        check("rd0_ready_count", 32'(ready_cnt - base), 32'd1);

        // write to slave 2 with five wait cycles
        base = ready_cnt;
        s_ready = 4'b0000;
        mem_valid = 1'b1; mem_addr = 32'h2000_0004; mem_wdata = 32'hA5A5_A5A5; mem_wstrb = 4'b0011;
        tick;
        check("wr2_s_wstrb", 32'(s_wstrb), 32'h3);
        check("wr2_s_wdata", s_wdata, 32'hA5A5_A5A5);
        check("wr2_s_addr", s_addr, 32'h2000_0004);
        hi = 0; other = '0;
        for (int i = 0; i < 6; i++) begin
            hi += int'(s_valid[2]);
            other |= s_valid & 4'b1011;
            if (i == 5) s_ready = 4'b0100;
            tick;
        end
        check("wr2_valid_cycles", 32'(hi), 32'd6);
        check("wr2_other_valid", 32'(other), 32'd0);
        check("wr2_mem_ready", 32'(mem_ready), 32'd1);
        check("wr2_bus_err", 32'(bus_err), 32'd0);
        check("wr2_s_valid_off", 32'(s_valid), 32'd0);
        mem_valid = 1'b0; s_ready = 4'b0000; mem_wstrb = 4'b0000;
        tick;
        check("wr2_ready_count", 32'(ready_cnt - base), 32'd1);

        // unmapped read
        mem_valid = 1'b1; mem_addr = 32'hF000_0000;
        tick;
        check("unm_mem_ready", 32'(mem_ready), 32'd1);
        check("unm_bus_err", 32'(bus_err), 32'd1);
        check("unm_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("unm_err_addr", err_addr, 32'hF000_0000);
        check("unm_s_valid", 32'(s_valid), 32'd0);
        mem_valid = 1'b0;
        tick;
        check("unm_ready_off", 32'(mem_ready), 32'd0);
        check("unm_err_off", 32'(bus_err), 32'd0);
        check("unm_err_addr_hold", err_addr, 32'hF000_0000);
        check("unm_s_valid_after", 32'(s_valid), 32'd0);

        // slave 1 never answers
        base = ready_cnt;
        mem_valid = 1'b1; mem_addr = 32'h1000_0000;
        tick;
`ifdef BUS_TIMEOUT_EN
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            hi += int'(s_valid[1]);
            tick;
        end
        check("to_valid_cycles", 32'(hi), 32'd8);
        check("to_mem_ready", 32'(mem_ready), 32'd1);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("to_err_addr", err_addr, 32'h1000_0000);
        check("to_s_valid_off", 32'(s_valid), 32'd0);
        mem_valid = 1'b0;
        tick;
`else
        for (int i = 0; i < 1000; i++) tick;
        check("stall_no_ready", 32'(ready_cnt - base), 32'd0);
        check("stall_s_valid", 32'(s_valid), 32'h2);
        mem_valid = 1'b0;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
`endif

        // asynchronous reset during a slave 3 access
        mem_valid = 1'b1; mem_addr = 32'h3000_0000; s_ready = 4'b0000;
        tick;
        check("rst3_s_valid", 32'(s_valid), 32'h8);
        tick;
        #2 reset_n = 1'b0;
        #1;
        check("rst3_s_valid_off", 32'(s_valid), 32'd0);
        check("rst3_mem_ready", 32'(mem_ready), 32'd0);
        check("rst3_bus_err", 32'(bus_err), 32'd0);
        check("rst3_err_addr", err_addr, 32'd0);
        mem_valid = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
        base = ready_cnt;
        slot0 = 32'hCAFE_0000; s_ready = 4'b0001;
        mem_valid = 1'b1; mem_addr = 32'h0000_0020;
        tick;
        check("post_s_valid", 32'(s_valid), 32'h1);
        tick;
        check("post_mem_ready", 32'(mem_ready), 32'd1);
        check("post_mem_rdata", mem_rdata, 32'hCAFE_0000);
        mem_valid = 1'b0;
        tick;
        check("post_ready_count", 32'(ready_cnt - base), 32'd1);

        // back-to-back reads: slave 1 then slave 0, second valid held through DONE
        base = ready_cnt;
        s_ready = 4'b0011;
        mem_valid = 1'b1; mem_addr = 32'h1000_0008;
        tick;
        check("b2b_first_valid", 32'(s_valid), 32'h2);
        tick;
        check("b2b_first_ready", 32'(mem_ready), 32'd1);
        check("b2b_first_rdata", mem_rdata, 32'h1111_1111);
        mem_addr = 32'h0000_000C;
        tick;
        check("b2b_idle_valid", 32'(s_valid), 32'd0);
        check("b2b_idle_ready", 32'(mem_ready), 32'd0);
        tick;
        check("b2b_second_valid", 32'(s_valid), 32'h1);
        check("b2b_second_addr", s_addr, 32'h0000_000C);
        tick;
        check("b2b_second_ready", 32'(mem_ready), 32'd1);
        check("b2b_second_rdata", mem_rdata, 32'hCAFE_0000);
        mem_valid = 1'b0; s_ready = 4'b0000;
        tick;
        check("b2b_ready_count", 32'(ready_cnt - base), 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
